// File: rtl/dual_port_ram_ctrl.sv
// Simple dual-port RAM with byte-enable writes, 1- or 2-cycle read latency,
// selectable read-during-write behaviour and a hardware clear engine.
module dual_port_ram_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int DEPTH    = 16,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    input  logic                  clr_req,
    output logic                  ready,
    output logic                  drop_err
);

    localparam int                NB       = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
    logic              ready_q, ready_d;
    logic              drop_err_q, drop_err_d;
    logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
    logic              rd_valid1_q, rd_valid1_d;
    logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
    logic              rd_valid2_q, rd_valid2_d;

    logic              accept_s;
    logic              wr_in_range_s;
    logic              rd_in_range_s;
    logic              wr_ok_s;
    logic              rd_ok_s;
    logic [DATA_W-1:0] rd_word_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;

    // Request qualification, read word selection with read-during-write bypass
    always_comb begin
        accept_s      = (state_q == ST_READY);
        wr_in_range_s = ({1'b0, wr_addr} < DEPTH_C);
        rd_in_range_s = ({1'b0, rd_addr} < DEPTH_C);
        wr_ok_s       = accept_s && wr_en && wr_in_range_s;
        rd_ok_s       = accept_s && rd_en;
        if (!rd_in_range_s) begin
            rd_word_s = {DATA_W{1'b0}};
        end else if ((RDW_MODE == 1) && wr_ok_s && (wr_addr == rd_addr)) begin
            rd_word_s = merge_bytes(mem_q[rd_addr], wr_data, wr_be);
        end else begin
            rd_word_s = mem_q[rd_addr];
        end
    end

    // Next-state for the clear engine, memory write port and read pipeline
    always_comb begin
        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        ready_d     = ready_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = wr_addr;
        mem_wdata_s = {DATA_W{1'b0}};
        case (state_q)
            ST_INIT: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = init_ptr_q;
                if (init_ptr_q == LAST_PTR) begin
                    state_d    = ST_READY;
                    ready_d    = 1'b1;
                    init_ptr_d = {ADDR_W{1'b0}};
                end else begin
                    init_ptr_d = init_ptr_q + ADDR_W'(1);
                end
            end
            ST_READY: begin
                mem_we_s    = wr_ok_s;
                mem_wdata_s = merge_bytes(mem_q[wr_addr], wr_data, wr_be);
                // This cycle's requests are still served; clearing starts next cycle
                if (clr_req) begin
                    state_d    = ST_INIT;
                    ready_d    = 1'b0;
                    init_ptr_d = {ADDR_W{1'b0}};
                end else begin
                    state_d    = ST_READY;
                end
            end
            default: begin
                state_d    = ST_INIT;
                ready_d    = 1'b0;
                init_ptr_d = {ADDR_W{1'b0}};
            end
        endcase

        drop_err_d  = accept_s ? (wr_en && !wr_in_range_s) : (wr_en || rd_en);
        rd_valid1_d = rd_ok_s;
        rd_data1_d  = rd_ok_s ? rd_word_s : rd_data1_q;
        rd_valid2_d = rd_valid1_q;
        rd_data2_d  = rd_valid1_q ? rd_data1_q : rd_data2_q;
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            init_ptr_q  <= {ADDR_W{1'b0}};
            ready_q     <= 1'b0;
            drop_err_q  <= 1'b0;
            rd_data1_q  <= {DATA_W{1'b0}};
            rd_valid1_q <= 1'b0;
            rd_data2_q  <= {DATA_W{1'b0}};
            rd_valid2_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            ready_q     <= ready_d;
            drop_err_q  <= drop_err_d;
            rd_data1_q  <= rd_data1_d;
            rd_valid1_q <= rd_valid1_d;
            rd_data2_q  <= rd_data2_d;
            rd_valid2_q <= rd_valid2_d;
        end
    end

    // Storage array; contents are cleared by the INIT sweep, not by reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign rd_data  = (RD_LAT == 2) ? rd_data2_q  : rd_data1_q;
    assign rd_valid = (RD_LAT == 2) ? rd_valid2_q : rd_valid1_q;
    assign ready    = ready_q;
    assign drop_err = drop_err_q;

endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// Scoreboard bench: two configurations driven by shared stimulus and checked
// against a word-array reference model with an init countdown.
module tb_dual_port_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_be = 4'h0;
    logic [3:0]  wr_addr = 4'h0;
    logic [31:0] wr_data = 32'h0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = 4'h0;
    logic        clr_req = 1'b0;

    logic [7:0]  rd_data0;
    logic        rd_valid0, ready0, drop0;
    logic [31:0] rd_data1;
    logic        rd_valid1, ready1, drop1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: per configuration word array and remaining clear cycles
    int          dep [2] = '{16, 12};
    logic [31:0] mmem [2][16];
    int          busy [2];
    logic [31:0] rq0 [$];
    logic [31:0] rq1 [$];
    bit          dq0 [$];
    bit          dq1 [$];
    logic [31:0] last0 = 32'h0;
    logic [31:0] last1 = 32'h0;

    always #5 clk = ~clk;

    dual_port_ram_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .RD_LAT(1), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_be(wr_be[0:0]), .wr_addr(wr_addr),
        .wr_data(wr_data[7:0]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .clr_req(clr_req), .ready(ready0), .drop_err(drop0)
    );

    dual_port_ram_ctrl #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .RD_LAT(2), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .clr_req(clr_req), .ready(ready1), .drop_err(drop1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] be);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) o[8*i +: 8] = n[8*i +: 8];
        end
        return o;
    endfunction

    task automatic model(input int k, input bit we, input logic [3:0] be, input int wa,
                         input logic [31:0] wd, input bit re, input int ra, input bit clr);
        logic [31:0] wdk;
        logic [3:0]  bek;
        logic [31:0] exp;
        bit          drop;
        wdk = (k == 1) ? wd : {24'h0, wd[7:0]};
        bek = (k == 1) ? be : {3'b000, be[0]};
        if (busy[k] == 0) begin
            if (re) begin
                exp = (ra < dep[k]) ? mmem[k][ra] : 32'h0;
                if (k == 1 && we && wa == ra && wa < dep[k]) exp = bmerge(exp, wdk, bek);
                if (k == 0) rq0.push_back(exp); else rq1.push_back(exp);
            end
            drop = we && (wa >= dep[k]);
            if (we && wa < dep[k]) mmem[k][wa] = bmerge(mmem[k][wa], wdk, bek);
            if (clr) begin
                busy[k] = dep[k];
                for (int i = 0; i < 16; i++) mmem[k][i] = 32'h0;
            end
        end else begin
            drop = we || re;
            busy[k]--;
        end
        if (k == 0) dq0.push_back(drop); else dq1.push_back(drop);
    endtask

    // Called at a falling edge; drives one cycle of stimulus and returns at the next one
    task automatic cycle(input bit we, input logic [3:0] be, input int wa, input logic [31:0] wd,
                         input bit re, input int ra, input bit clr);
        wr_en = we; wr_be = be; wr_addr = wa[3:0]; wr_data = wd;
        rd_en = re; rd_addr = ra[3:0]; clr_req = clr;
        chk("ready0", {31'b0, ready0}, {31'b0, busy[0] == 0});
        chk("ready1", {31'b0, ready1}, {31'b0, busy[1] == 0});
        model(0, we, be, wa, wd, re, ra, clr);
        model(1, we, be, wa, wd, re, ra, clr);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 0, 32'h0, 1'b0, 0, 1'b0);
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
        rq0.delete(); rq1.delete(); dq0.delete(); dq1.delete();
        last0 = 32'h0; last1 = 32'h0;
        #1;
        chk("rst_ready0", {31'b0, ready0}, 32'h0);
        chk("rst_ready1", {31'b0, ready1}, 32'h0);
        chk("rst_valid0", {31'b0, rd_valid0}, 32'h0);
        chk("rst_valid1", {31'b0, rd_valid1}, 32'h0);
        chk("rst_data0", {24'h0, rd_data0}, 32'h0);
        chk("rst_data1", rd_data1, 32'h0);
        chk("rst_drop0", {31'b0, drop0}, 32'h0);
        chk("rst_drop1", {31'b0, drop1}, 32'h0);
        for (int i = 0; i < hold; i++) @(negedge clk);
        rst = 1'b1;
        busy[0] = dep[0];
        busy[1] = dep[1];
        for (int i = 0; i < 16; i++) begin
            mmem[0][i] = 32'h0;
            mmem[1][i] = 32'h0;
        end
    endtask

    // Monitor: pops expected read words on rd_valid and expected drop flags every cycle
    always @(posedge clk) begin
        logic [31:0] e;
        bit          d;
        #1;
        if (rst) begin
            if (rd_valid0) begin
                if (rq0.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL rd_valid0_spurious: actual=1 required=0 at %0t", $time);
                end else begin
                    e = rq0.pop_front();
                    chk("rd_data0", {24'h0, rd_data0}, e);
                    last0 = e;
                end
            end else begin
                chk("rd_hold0", {24'h0, rd_data0}, last0);
            end
            if (rd_valid1) begin
                if (rq1.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL rd_valid1_spurious: actual=1 required=0 at %0t", $time);
                end else begin
                    e = rq1.pop_front();
                    chk("rd_data1", rd_data1, e);
                    last1 = e;
                end
            end else begin
                chk("rd_hold1", rd_data1, last1);
            end
            d = (dq0.size() != 0) ? dq0.pop_front() : 1'b0;
            chk("drop_err0", {31'b0, drop0}, {31'b0, d});
            d = (dq1.size() != 0) ? dq1.pop_front() : 1'b0;
            chk("drop_err1", {31'b0, drop1}, {31'b0, d});
        end
    end

    initial begin
        @(negedge clk);
        do_reset(3);
        idle(17);
        for (int i = 0; i < 16; i++) cycle(1'b0, 4'h0, 0, 32'h0, 1'b1, i, 1'b0);

        cycle(1'b1, 4'hF, 3, 32'h000000A5, 1'b0, 0, 1'b0);
        cycle(1'b0, 4'h0, 0, 32'h0, 1'b1, 3, 1'b0);
        cycle(1'b1, 4'hF, 5, 32'h11223344, 1'b0, 0, 1'b0);
        cycle(1'b1, 4'b0101, 5, 32'hAABBCCDD, 1'b0, 0, 1'b0);
        cycle(1'b0, 4'h0, 0, 32'h0, 1'b1, 5, 1'b0);
        cycle(1'b1, 4'hF, 7, 32'h0000005A, 1'b1, 7, 1'b0);
        cycle(1'b1, 4'b0010, 7, 32'h0000C300, 1'b1, 7, 1'b0);
        idle(2);

        for (int i = 0; i < 16; i++) cycle(1'b1, 4'hF, i, $urandom, 1'b0, 0, 1'b0);
        cycle(1'b1, 4'hF, 2, 32'h77777777, 1'b1, 2, 1'b1);
        for (int i = 0; i < 16; i++) cycle(i % 3 == 0, 4'hF, i, 32'hFFFFFFFF, i == 5, 1, i == 4);
        idle(1);
        for (int i = 0; i < 16; i++) cycle(1'b0, 4'h0, 0, 32'h0, 1'b1, i, 1'b0);

        cycle(1'b1, 4'hF, 9, 32'hC3C3C3C3, 1'b0, 0, 1'b0);
        cycle(1'b0, 4'h0, 0, 32'h0, 1'b1, 9, 1'b0);
        idle(2);
        cycle(1'b0, 4'h0, 0, 32'h0, 1'b0, 0, 1'b1);
        idle(8);
        do_reset(2);
        idle(17);
        for (int i = 0; i < 16; i++) cycle(1'b0, 4'h0, 0, 32'h0, 1'b1, i, 1'b0);

        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 1) == 1, 4'($urandom), int'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
                  $urandom_range(0, 49) == 0);
        end
        idle(4);
        chk("rq0_drained", rq0.size(), 32'h0);
        chk("rq1_drained", rq1.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
